halton_nd_gen: RTL
==================

HALTON_ND_GEN -- requirements
Module: halton_nd_gen

Interface
REQ-001 SHALL have parameter NCH, default 3: number of channels (dimensions), legal range 1..4.
REQ-002 SHALL have parameter BASES, default {4'd7,4'd3,4'd2}: packed 4-bit base per channel, channel c at bits [4c+3:4c], each 2..15.
REQ-003 SHALL have parameter COUNT_W, default 32: sequence index width.
REQ-004 SHALL have parameter WIDTH, default 32: output fraction bits per channel, unsigned Q0.WIDTH.
REQ-005 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-007 SHALL have port pop_enable input 1: request next point; sampled only in IDLE.
REQ-008 SHALL have port seed input COUNT_W: index loaded on reseed.
REQ-009 SHALL have port leap input 8: index stride latched on reseed; 0 treated as 1.
REQ-010 SHALL have port reseed_enable input 1: load seed/leap, abort any computation.
REQ-011 SHALL have port out_data output NCH*WIDTH: channel c at [WIDTH*c+WIDTH-1:WIDTH*c].
REQ-012 SHALL have port out_index output COUNT_W: index k that produced out_data.
REQ-013 SHALL have port out_valid output 1: out_data/out_index valid; held until accepted.
REQ-014 SHALL have port out_ready input 1: consumer accepts when out_valid&out_ready at a rising edge.
REQ-015 SHALL have port busy output 1: high in DIGIT and DIV states.

Function
REQ-016 SHALL compute per channel c: out = floor(vdc(k,B_c)*2^WIDTH), vdc = radical inverse of k in base B_c.
REQ-017 SHALL implement states IDLE, DIGIT, DIV, HOLD.
REQ-018 IDLE & pop_enable & !reseed_enable: latch k=count, count <= count+leap (mod 2^COUNT_W), per channel q=k, R=0, P=1, go DIGIT.
REQ-019 DIGIT, per channel per cycle: d=q mod B, q<=q/B, R<=R*B+d, P<=P*B; channel done when new q==0 (min 1 cycle, so k=0 uses 1 cycle).
REQ-020 Finished channels SHALL hold R,P; DIGIT lasts Dmax = max over channels of base-B_c digit count of k; then go DIV.
REQ-021 DIV: restoring division of R*2^WIDTH by P, one quotient bit per cycle, MSB first, exactly WIDTH cycles, all channels in lockstep; then HOLD.
REQ-022 R and P registers SHALL be COUNT_W+4 bits; R<P guarantees quotient < 2^WIDTH, no overflow/saturation.
REQ-023 out_valid SHALL rise exactly Dmax+WIDTH rising edges after the pop-accepting edge; out_data/out_index update at that edge.
REQ-024 HOLD: out_valid=1, outputs stable until out_ready; on handshake clear out_valid, go IDLE (next pop accepted no earlier than following edge).
REQ-025 reseed_enable in any state SHALL at that edge: count<=seed, leap_reg<=(leap==0?1:leap), out_valid<=0, go IDLE; reseed beats simultaneous pop.
REQ-026 pop_enable outside IDLE SHALL be ignored (no queueing); out_data holds last value after handshake.
REQ-027 count SHALL wrap from 2^COUNT_W-1 modulo 2^COUNT_W without error.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, count=0, leap_reg=1, out_data=0, out_index=0, out_valid=0, busy=0.
REQ-029 Reset deassertion mid-computation SHALL leave no residue; first pop after reset computes k=0.

Verification (defaults, BASES {7,3,2}, WIDTH 32)
REQ-030 Reset, pop, ready=1 -> out_valid 33 edges later, data {0,0,0}, index 0; next pop -> index 1, ch0=0x80000000, ch1=0x55555555, ch2=0x24924924, latency 33.
REQ-031 Reseed seed=5 leap=0, pop -> index 5, ch0=0xA0000000, ch1=0xC71C71C7, ch2=0xB6DB6DB6, latency 35 (Dmax=3); next pop index 6.
REQ-032 Hold out_ready=0 for 10 cycles in HOLD -> out_valid, out_data, out_index stable; extra pop pulses ignored; release -> one transfer.
REQ-033 Reseed asserted mid-DIV with simultaneous pop -> out_valid stays 0, state IDLE, next pop returns seed index.
REQ-034 Reseed seed=2^32-1 leap=2, two pops -> out_index 0xFFFFFFFF then 0x00000001; ch0 first = 0xFFFFFFFF.
REQ-035 rst_n low mid-DIGIT -> all outputs 0 immediately (asynchronous, before next edge); next pop computes index 0.

Source files
------------

// File: rtl/halton_nd_gen.sv
// Multi-channel Halton point generator: digit-reversal per base, then a
// shared-timing restoring divide turning R/P into a Q0.WIDTH fraction.
module halton_nd_gen #(
  parameter int unsigned       NCH     = 3,
  parameter logic [4*NCH-1:0]  BASES   = {4'd7, 4'd3, 4'd2},
  parameter int unsigned       COUNT_W = 32,
  parameter int unsigned       WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pop_enable,
  input  logic [COUNT_W-1:0]     seed,
  input  logic [7:0]             leap,
  input  logic                   reseed_enable,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0]     out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int unsigned RW = COUNT_W + 4;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StDigit, StDiv, StHold} state_e;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [7:0]           leap_q, leap_d;
  logic [COUNT_W-1:0]   k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NCH-1:0]       done_q, done_d;
  logic [COUNT_W-1:0]   q_q [NCH];
  logic [COUNT_W-1:0]   q_d [NCH];
  logic [RW-1:0]        r_q [NCH];
  logic [RW-1:0]        r_d [NCH];
  logic [RW-1:0]        p_q [NCH];
  logic [RW-1:0]        p_d [NCH];
  logic [WIDTH-1:0]     quo_q [NCH];
  logic [WIDTH-1:0]     quo_d [NCH];
  logic [NCH*WIDTH-1:0] out_data_q, out_data_d;
  logic [COUNT_W-1:0]   out_index_q, out_index_d;
  logic                 out_valid_q, out_valid_d;

  logic [COUNT_W-1:0]   base_w;
  logic [COUNT_W-1:0]   qdiv;
  logic [RW:0]          rem2;
  logic                 ge;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    leap_d      = leap_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    q_d         = q_q;
    r_d         = r_q;
    p_d         = p_q;
    quo_d       = quo_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    base_w      = '0;
    qdiv        = '0;
    rem2        = '0;
    ge          = 1'b0;

    if (reseed_enable) begin
      // Reseed aborts whatever is in flight and wins over a same-cycle pop.
      count_d     = seed;
      leap_d      = (leap == 8'd0) ? 8'd1 : leap;
      out_valid_d = 1'b0;
      state_d     = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop_enable) begin
            k_d     = count_q;
            count_d = count_q + COUNT_W'(leap_q);
            done_d  = '0;
            for (int c = 0; c < NCH; c++) begin
              q_d[c] = count_q;
              r_d[c] = '0;
              p_d[c] = RW'(1);
            end
            state_d = StDigit;
          end
        end
        StDigit: begin
          for (int c = 0; c < NCH; c++) begin
            if (!done_q[c]) begin
              base_w    = COUNT_W'(BASES[4*c +: 4]);
              qdiv      = q_q[c] / base_w;
              q_d[c]    = qdiv;
              r_d[c]    = r_q[c] * RW'(base_w) + RW'(q_q[c] % base_w);
              p_d[c]    = p_q[c] * RW'(base_w);
              done_d[c] = (qdiv == '0);
            end
          end
          if (&done_d) begin
            cnt_d   = '0;
            state_d = StDiv;
          end
        end
        StDiv: begin
          // R < P holds throughout, so the partial remainder fits RW bits.
          for (int c = 0; c < NCH; c++) begin
            rem2     = {r_q[c], 1'b0};
            ge       = (rem2 >= {1'b0, p_q[c]});
            r_d[c]   = ge ? RW'(rem2 - {1'b0, p_q[c]}) : RW'(rem2);
            quo_d[c] = {quo_q[c][WIDTH-2:0], ge};
            out_data_d[WIDTH*c +: WIDTH] = quo_d[c];
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            out_index_d = k_q;
            out_valid_d = 1'b1;
            state_d     = StHold;
          end else begin
            out_data_d = out_data_q;
            cnt_d      = cnt_q + CW'(1);
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      leap_q      <= 8'd1;
      k_q         <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        q_q[c]   <= '0;
        r_q[c]   <= '0;
        p_q[c]   <= '0;
        quo_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      leap_q      <= leap_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < NCH; c++) begin
        q_q[c]   <= q_d[c];
        r_q[c]   <= r_d[c];
        p_q[c]   <= p_d[c];
        quo_q[c] <= quo_d[c];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == StDigit) || (state_q == StDiv);

endmodule
